// File: rtl/spi_rx_sync.sv
// SPI peripheral receiver running on the system clock; SCK/SS/MOSI are oversampled through 2-flop synchronizers.
// Define SPI_RX_FRAME_CNT_EN to add the FRAME_CNT completed-frame counter port.
module spi_rx_sync #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY
`ifdef SPI_RX_FRAME_CNT_EN
  ,
  output logic [7:0]       FRAME_CNT
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic             sck_m, sck_s, sck_d;
  logic             ss_m, ss_s, ss_d;
  logic             mosi_m, mosi_s;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_next;
  logic [CW-1:0]    bit_cnt;
  logic             first;
  logic             lead_edge, trail_edge, sample_edge, shift_edge, last_sample;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      ss_m   <= 1'b0;
      ss_s   <= 1'b0;
      ss_d   <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= SCK;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      ss_m   <= SS;
      ss_s   <= ss_m;
      ss_d   <= ss_s;
      mosi_m <= MOSI;
      mosi_s <= mosi_m;
    end
  end

  assign lead_edge   = (sck_d == CKP) && (sck_s != CKP);
  assign trail_edge  = (sck_d != CKP) && (sck_s == CKP);
  assign sample_edge = CPH ? trail_edge : lead_edge;
  assign shift_edge  = CPH ? lead_edge : trail_edge;
  assign last_sample = sample_edge && (bit_cnt == CW'(WIDTH - 1));
  assign rx_next     = (rx_sh << 1) | {{(WIDTH-1){1'b0}}, mosi_s};
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      first    <= 1'b0;
      MISO     <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
`ifdef SPI_RX_FRAME_CNT_EN
      FRAME_CNT <= 8'd0;
`endif
    end else begin
      RX_VALID <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (ENB && ss_d && !ss_s) state <= LOAD;
        end
        LOAD: begin
          tx_sh   <= TX_DATA;
          rx_sh   <= '0;
          bit_cnt <= '0;
          first   <= 1'b1;
          if (ss_s) begin
            state <= IDLE;
            MISO  <= 1'b0;
          end else begin
            state <= ACTIVE;
            // A back-to-back CPH=1 frame may see its first shift edge while still loading.
            if (!CPH) begin
              MISO <= TX_DATA[WIDTH-1];
            end else if (shift_edge) begin
              MISO  <= TX_DATA[WIDTH-1];
              first <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (last_sample) begin
            rx_sh    <= rx_next;
            RX_DATA  <= rx_next;
            RX_VALID <= 1'b1;
            bit_cnt  <= bit_cnt + CW'(1);
            state    <= DONE;
`ifdef SPI_RX_FRAME_CNT_EN
            FRAME_CNT <= FRAME_CNT + 8'd1;
`endif
          end else if (ss_s) begin
            state <= IDLE;
            MISO  <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + CW'(1);
            end
            if (shift_edge) begin
              // In CPH=0 a trailing edge before any sample is the tail of the previous frame.
              if (!CPH) begin
                if (bit_cnt != '0) begin
                  tx_sh <= tx_sh << 1;
                  MISO  <= tx_sh[WIDTH-2];
                end
              end else if (first) begin
                MISO  <= tx_sh[WIDTH-1];
                first <= 1'b0;
              end else begin
                tx_sh <= tx_sh << 1;
                MISO  <= tx_sh[WIDTH-2];
              end
            end
          end
        end
        DONE: begin
          if (ss_s) begin
            state <= IDLE;
            MISO  <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_sync.sv
// Randomized bench for spi_rx_sync acting as an SPI controller; expected words come from a queue model.
module tb_spi_rx_sync;

  logic       clk = 1'b0;
  logic       reset, enb, ckp, cph, sck, ss, mosi;
  logic [7:0] tx_data;
  logic       miso, rx_valid, busy;
  logic [7:0] rx_data;
  logic [7:0] frame_cnt;

  int         n_chk = 0;
  int         n_fail = 0;
  int         rv_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fc_model = 8'd0;

  always #5 clk = ~clk;

  spi_rx_sync #(.WIDTH(8)) dut (
    .CLK(clk), .RESET(reset), .ENB(enb), .CKP(ckp), .CPH(cph),
    .SCK(sck), .SS(ss), .MOSI(mosi), .MISO(miso),
    .TX_DATA(tx_data), .RX_DATA(rx_data), .RX_VALID(rx_valid), .BUSY(busy)
`ifdef SPI_RX_FRAME_CNT_EN
    , .FRAME_CNT(frame_cnt)
`endif
  );

`ifndef SPI_RX_FRAME_CNT_EN
  assign frame_cnt = 8'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Every RX_VALID pulse must deliver the oldest completed frame still outstanding.
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk("rx_spurious", 32'(exp_q.size()), 32'd1);
      else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic h);
    ckp = p;
    cph = h;
    sck = p;
    wait_clk(6);
  endtask

  task automatic cs_low();
    ss = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    ss = 1'b1;
    wait_clk(6);
  endtask

  // Controller side: drive MOSI on shift edges, capture MISO at sample edges.
  task automatic spi_xfer(input logic [7:0] mw, input int nbits, input int h,
                          input logic [7:0] tnext, output logic [31:0] got);
    got = 32'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cph) begin
        mosi = mw[i];
        wait_clk(h);
        got = {got[30:0], miso};
        sck = ~ckp;
        if (i == 0) tx_data = tnext;
        wait_clk(h);
        sck = ckp;
      end else begin
        sck  = ~ckp;
        mosi = mw[i];
        wait_clk(h);
        got = {got[30:0], miso};
        sck = ckp;
        if (i == 0) tx_data = tnext;
        wait_clk(h);
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] mw, input logic [7:0] tw, input logic [7:0] tnext, input int h);
    logic [31:0] got;
    exp_q.push_back(mw);
    spi_xfer(mw, 8, h, tnext, got);
    chk("miso_word", got, {24'd0, tw});
    fc_model = fc_model + 8'd1;
  endtask

  task automatic abort_frame(input logic [7:0] mw, input int nbits, input int h);
    logic [31:0] got;
    spi_xfer(mw, nbits, h, tx_data, got);
    ss = 1'b1;
    wait_clk(4);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_miso", {31'd0, miso}, 32'd0);
    wait_clk(4);
  endtask

  initial begin
    int          rv0;
    logic [31:0] got;
    logic [7:0]  cur_tx, nxt_tx, mw;
    int          h, nfr;
    reset = 1'b1; enb = 1'b1; ckp = 1'b0; cph = 1'b0; sck = 1'b0;
    ss = 1'b1; mosi = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    reset = 1'b0;
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
`ifdef SPI_RX_FRAME_CNT_EN
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`endif

    // Mode 0 single frame
    set_mode(1'b0, 1'b0);
    tx_data = 8'h3C;
    rv0 = rv_cnt;
    cs_low();
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    do_frame(8'hA5, 8'h3C, 8'h3C, 4);
    cs_high();
    chk("m0_one_pulse", 32'(rv_cnt - rv0), 32'd1);
    chk("m0_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Abort after 5 bits of 0xFF
    rv0 = rv_cnt;
    cs_low();
    abort_frame(8'hFF, 5, 4);
    chk("abort_no_pulse", 32'(rv_cnt - rv0), 32'd0);
    chk("abort_rx_kept", {24'd0, rx_data}, 32'hA5);
`ifdef SPI_RX_FRAME_CNT_EN
    chk("abort_fc", {24'd0, frame_cnt}, {24'd0, fc_model});
`endif

    // Mode 3 single frame
    set_mode(1'b1, 1'b1);
    tx_data = 8'hC3;
    cs_low();
    do_frame(8'h5A, 8'hC3, 8'hC3, 5);
    cs_high();
    chk("m3_rx_data", {24'd0, rx_data}, 32'h5A);

    // Back-to-back frames under one CS, TX word changed between frames
    set_mode(1'b0, 1'b0);
    tx_data = 8'h3C;
    rv0 = rv_cnt;
    cs_low();
    do_frame(8'h11, 8'h3C, 8'h77, 4);
    do_frame(8'h22, 8'h77, 8'h77, 4);
    cs_high();
    chk("b2b_pulses", 32'(rv_cnt - rv0), 32'd2);
    chk("b2b_rx_last", {24'd0, rx_data}, 32'h22);

    // ENB low: frames ignored entirely
    enb = 1'b0;
    rv0 = rv_cnt;
    cs_low();
    chk("enb0_busy", {31'd0, busy}, 32'd0);
    spi_xfer(8'h99, 8, 4, tx_data, got);
    cs_high();
    chk("enb0_no_pulse", 32'(rv_cnt - rv0), 32'd0);
    chk("enb0_miso_low", got, 32'd0);
    enb = 1'b1;

    // RESET mid-frame at bit 3, then a clean frame
    tx_data = 8'hE7;
    cs_low();
    spi_xfer(8'hF0, 3, 4, tx_data, got);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    fc_model = 8'd0;
    chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    cs_high();
    set_mode(1'b0, 1'b0);
    cs_low();
    do_frame(8'h81, 8'hE7, 8'hE7, 4);
    cs_high();
    chk("post_rst_rx", {24'd0, rx_data}, 32'h81);

    // Randomized modes, speeds, burst lengths and occasional aborts
    for (int it = 0; it < 24; it++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      h = $urandom_range(4, 6);
      nfr = $urandom_range(1, 3);
      cur_tx = 8'($urandom);
      tx_data = cur_tx;
      rv0 = rv_cnt;
      cs_low();
      for (int f = 0; f < nfr; f++) begin
        mw = 8'($urandom);
        nxt_tx = 8'($urandom);
        do_frame(mw, cur_tx, nxt_tx, h);
        cur_tx = nxt_tx;
      end
      if ($urandom_range(0, 3) == 0) abort_frame(8'($urandom), $urandom_range(1, 7), h);
      else cs_high();
      chk("rand_pulses", 32'(rv_cnt - rv0), 32'(nfr));
      chk("rand_pending", 32'(exp_q.size()), 32'd0);
    end
`ifdef SPI_RX_FRAME_CNT_EN
    chk("rand_fc", {24'd0, frame_cnt}, {24'd0, fc_model});
    set_mode(1'b0, 1'b0);
    cs_low();
    for (int f = 0; f < 257; f++) do_frame(8'(f), tx_data, tx_data, 4);
    cs_high();
    chk("fc_257", {24'd0, frame_cnt}, {24'd0, fc_model});
    cs_low();
    abort_frame(8'h0F, 4, 4);
    chk("fc_after_abort", {24'd0, frame_cnt}, {24'd0, fc_model});
`endif
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
